rs_dec_correct: RTL
===================

Name: rs_dec_correct

Overview:
Final stage of the RS decoder, directly downstream of the Chien/Forney search stage. It buffers the received codeword symbols while syndrome, Berlekamp-Massey and search complete. It then joins each buffered symbol with the per-symbol error-location/magnitude stream from the search. It emits the corrected symbol stream, a per-codeword error count and a decode-failure flag.

Parameters:
BITSPERSYMBOL, 8, symbol width in bits
CHECK, 32, check symbols per codeword; correctable errors = CHECK/2
N, 255, codeword length in symbols (fixed-length codewords only)
FIFO_DEPTH, 1024, received-symbol buffer depth; power of 2; must be at least the decoder latency plus N
CNTW, 5, width of error count; equals clog2(CHECK/2)+1

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low (0 = reset), deasserted synchronously
rx_data  in  BITSPERSYMBOL  received symbol, same stream that feeds the syndrome stage
rx_valid  in  1  rx_data valid
rx_sop  in  1  first symbol of codeword
rx_eop  in  1  last symbol of codeword
rx_ready  out  1  buffer can accept a symbol
sch_valid  in  1  search output valid
sch_sop  in  1  search output, first symbol position
sch_eop  in  1  search output, last symbol position
sch_error_location  in  1  current symbol position is in error
sch_error_magnitude  in  BITSPERSYMBOL  XOR correction value
sch_error  in  1  decode failure for this codeword, valid with sch_eop
sch_error_count  in  CNTW  errors reported by BM, valid with sch_eop
sch_ready  out  1  stage consumes a search beat
out_data  out  BITSPERSYMBOL  corrected symbol
out_valid  out  1  output beat valid
out_sop  out  1  first corrected symbol
out_eop  out  1  last corrected symbol
out_ready  in  1  downstream accepts
out_decfail  out  1  codeword uncorrectable, valid with out_eop
out_num_err  out  CNTW  corrections applied in codeword, valid with out_eop
align_err  out  1  sticky: rx/search framing mismatch detected

Behaviour:
- Reset (rst=0, async): FIFO empty; all out_* signals, align_err and the internal correction counter = 0; rx_ready = 0 while in reset.
- rx_ready = !fifo_full. A push occurs on rx_valid && rx_ready. Symbol, sop and eop are stored together.
- Join. Define advance = !out_valid || out_ready.
  - fire = fifo_nonempty && sch_valid && advance.
  - sch_ready = fifo_nonempty && advance.
  - A FIFO pop occurs only on fire.
- On fire, the output register loads on the next edge (1-cycle latency from join):
  - out_data = head ^ (sch_error_location ? sch_error_magnitude : 0).
  - out_sop = head.sop and out_eop = head.eop.
- Correction counter:
  - Increments when sch_error_location=1 && sch_error_magnitude!=0.
  - Clears after an eop beat.
  - On the eop beat, out_num_err = count including that beat.
- out_decfail = sch_error on the eop beat, else 0.
- When sch_error=1, symbols pass through uncorrected for the whole codeword. The stage latches sch_error at the sch_sop beat; the search asserts it for the full codeword.
- No fire and out_ready=1: out_valid drops to 0 next cycle. out_valid=1 with out_ready=0: all out_* signals hold stable.
- Alignment: on fire, if head.sop != sch_sop or head.eop != sch_eop, align_err is set. It is sticky until reset; data still flows.
- Full FIFO: rx_ready=0 and no push, even if a pop occurs in the same cycle (registered full, no bypass).
- Empty FIFO: sch_ready=0, so the search stalls.
- Simultaneous push and pop when not full: both occur and occupancy is unchanged.
- Read/write pointers wrap modulo FIFO_DEPTH. Occupancy counter width is clog2(FIFO_DEPTH)+1.
- Reset mid-codeword: all state is flushed; partially output codewords are not completed.

Decomposition:
- Package rs_dec_pkg holds BITSPERSYMBOL, CHECK, N, CNTW defaults, the clog2 function, and a packed type for symbol+sop+eop.
- One sub-module: rs_dec_sym_fifo, a synchronous single-clock FIFO (width BITSPERSYMBOL+2, depth FIFO_DEPTH, full/empty/push/pop, async active-low reset).
- Join, correction counter and output register live in rs_dec_correct.

Test Plan:
1. Clean codeword: rx symbols 0..254, search all location=0, sch_error_count=0 → out_data 0..254 unchanged, sop on 0, eop on 254, out_num_err=0, out_decfail=0.
2. Three errors: location=1 at symbols 3, 100, 254 with magnitudes 0x5A, 0xFF, 0x01 → those outputs equal rx^mag, out_num_err=3 on eop.
3. Decode failure: sch_error=1 and location=1 at symbol 10 → symbol 10 unmodified, out_decfail=1 and out_num_err=0 on eop.
4. Backpressure: out_ready toggled 1-0-0-1 with random sch_valid gaps; FIFO_DEPTH=16 and rx blasting → rx_ready drops at 16 entries, no symbol lost or duplicated, outputs stable while out_ready=0.
5. Misalignment: sch_sop asserted one beat late → align_err=1 from the cycle after that fire and stays 1 through the next clean codeword.
6. Async reset asserted mid-codeword (symbol 120) → out_valid=0 and rx_ready=0 immediately; after release, a fresh codeword passes with correct sop/eop.

Source files
------------

// File: rtl/rs_dec_pkg.sv
// Shared constants and types for the RS decoder correction stage.
// The symbol buffer stores a symbol together with its frame markers.
package rs_dec_pkg;
    localparam int BITSPERSYMBOL = 8;
    localparam int CHECK         = 32;
    localparam int N             = 255;
    localparam int CNTW          = 5;
    localparam int FIFO_DEPTH    = 1024;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    typedef struct packed {
        logic                     sop;
        logic                     eop;
        logic [BITSPERSYMBOL-1:0] data;
    } sym_t;
endpackage

// File: rtl/rs_dec_sym_fifo.sv
// Single-clock symbol buffer with registered full/empty flags.
// Depth must be a power of two so the pointers wrap on their own.
module rs_dec_sym_fifo import rs_dec_pkg::*; #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int             AW       = clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      count, count_n;
    logic             do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_comb begin
        count_n = count;
        if (do_push && !do_pop)      count_n = count + 1'b1;
        else if (!do_push && do_pop) count_n = count - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count_n;
            full  <= (count_n == FULL_CNT);
            empty <= (count_n == '0);
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end
endmodule

// File: rtl/rs_dec_correct.sv
// Final RS decoder stage: joins buffered received symbols with the search
// stream, applies XOR corrections and reports per-codeword status.
module rs_dec_correct #(
    parameter int BITSPERSYMBOL = rs_dec_pkg::BITSPERSYMBOL,
    parameter int CHECK         = rs_dec_pkg::CHECK,
    parameter int FIFO_DEPTH    = rs_dec_pkg::FIFO_DEPTH,
    parameter int CNTW          = rs_dec_pkg::clog2(CHECK / 2) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BITSPERSYMBOL-1:0] rx_data,
    input  logic                     rx_valid,
    input  logic                     rx_sop,
    input  logic                     rx_eop,
    output logic                     rx_ready,
    input  logic                     sch_valid,
    input  logic                     sch_sop,
    input  logic                     sch_eop,
    input  logic                     sch_error_location,
    input  logic [BITSPERSYMBOL-1:0] sch_error_magnitude,
    input  logic                     sch_error,
    input  logic [CNTW-1:0]          sch_error_count,
    output logic                     sch_ready,
    output logic [BITSPERSYMBOL-1:0] out_data,
    output logic                     out_valid,
    output logic                     out_sop,
    output logic                     out_eop,
    input  logic                     out_ready,
    output logic                     out_decfail,
    output logic [CNTW-1:0]          out_num_err,
    output logic                     align_err
);
    import rs_dec_pkg::*;

    localparam int FW = BITSPERSYMBOL + 2;

    logic [FW-1:0]            head;
    logic                     head_sop, head_eop;
    logic [BITSPERSYMBOL-1:0] head_data;
    logic                     full, empty, advance, fire;
    logic                     fail_q, fail_now, fix;
    logic [CNTW-1:0]          err_cnt, cnt_next;
    logic                     unused_bm_cnt;

    // BM's count is informational; the reported count is what was applied.
    assign unused_bm_cnt = ^sch_error_count;

    assign {head_sop, head_eop, head_data} = head;

    assign rx_ready  = rst && !full;
    assign advance   = !out_valid || out_ready;
    assign fire      = !empty && sch_valid && advance;
    assign sch_ready = !empty && advance;

    // Failure is latched on the search sop beat and covers the whole codeword.
    assign fail_now = sch_sop ? sch_error : fail_q;
    assign fix      = sch_error_location && (sch_error_magnitude != '0) && !fail_now;
    assign cnt_next = err_cnt + {{(CNTW-1){1'b0}}, fix};

    rs_dec_sym_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_valid && rx_ready),
        .wdata ({rx_sop, rx_eop, rx_data}),
        .pop   (fire),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_sop     <= 1'b0;
            out_eop     <= 1'b0;
            out_decfail <= 1'b0;
            out_num_err <= '0;
            align_err   <= 1'b0;
            err_cnt     <= '0;
            fail_q      <= 1'b0;
        end else if (fire) begin
            out_valid   <= 1'b1;
            out_data    <= head_data ^ (fix ? sch_error_magnitude : '0);
            out_sop     <= head_sop;
            out_eop     <= head_eop;
            out_decfail <= head_eop && sch_error;
            out_num_err <= head_eop ? cnt_next : '0;
            err_cnt     <= head_eop ? '0 : cnt_next;
            if (sch_sop) fail_q <= sch_error;
            if (head_sop != sch_sop || head_eop != sch_eop) align_err <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
